// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request, start, 8 data LSB first, odd parity, stop, device ack); define PS2_TX_RETRY_EN to retry failed frames up to MAX_RETRIES times
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_SETUP    = 16,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;
    localparam logic [2:0] FAIL      = 3'd6;
    localparam int MAX_A = (INHIBIT_CYCLES > START_SETUP) ? INHIBIT_CYCLES : START_SETUP;
    localparam int MAX_C = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int CW = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(START_SETUP - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES);

    if (INHIBIT_CYCLES < 1 || START_SETUP < 1 || TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0) begin : g_bad_params
        $error("ps2_host_tx: cycle counts must be positive and MAX_RETRIES non-negative");
    end

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    tx_byte;
    logic          parity;
    logic          clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic          fall, timeout, retry, data_bit;

    assign fall     = clk_prev & ~clk_sync;
    assign timeout  = cnt == TMO_LAST;
    assign data_bit = (bit_cnt < 4'd8) ? ~tx_byte[bit_cnt[2:0]] : (bit_cnt == 4'd8) ? ~parity : 1'b0;

`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retry_cnt;

    assign retry = retry_cnt < RW'(MAX_RETRIES);

    // failed attempts of the current byte; cleared whenever the transmitter goes idle
    always_ff @(posedge clk) begin
        if (!reset)
            retry_cnt <= '0;
        else if (state_n == IDLE)
            retry_cnt <= '0;
        else if (state == FAIL && retry)
            retry_cnt <= retry_cnt + 1'b1;
    end
`else
    assign retry = 1'b0;
`endif

    // two-flop synchronisers on both pins and falling-edge history of the device clock
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // frame sequencing: timeout beats a late ack, fall 11 carries the device ack bit
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = tx_start ? INHIBIT : IDLE;
            INHIBIT:   state_n = (cnt == INH_LAST) ? REQ : INHIBIT;
            REQ:       state_n = (cnt == REQ_LAST) ? SEND : REQ;
            SEND:      state_n = timeout ? FAIL : (fall && bit_cnt == 4'd10) ? (data_sync ? FAIL : WAIT_IDLE) : SEND;
            WAIT_IDLE: state_n = timeout ? FAIL : (clk_sync && data_sync) ? DONE : WAIT_IDLE;
            DONE:      state_n = IDLE;
            FAIL:      state_n = retry ? INHIBIT : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // state, shared phase/timeout counter, bit serialisation and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            tx_byte     <= '0;
            parity      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= (state_n == IDLE || (state_n != state && state_n != WAIT_IDLE)) ? '0 : cnt + 1'b1;
            bit_cnt     <= (state != SEND) ? 4'd0 : fall ? bit_cnt + 4'd1 : bit_cnt;
            if (state == IDLE && tx_start) begin
                tx_byte <= tx_data;
                parity  <= ~^tx_data;
            end
            ps2_clk_oe  <= state == INHIBIT || state == REQ;
            ps2_data_oe <= (state == REQ) || (state == SEND && (fall ? data_bit : ps2_data_oe));
            tx_ready    <= state_n == IDLE;
            busy        <= state_n != IDLE;
            tx_done     <= state_n == DONE;
            tx_error    <= state_n == FAIL && !retry;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx driven by a behavioural PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 8;
    localparam int SETUP = 4;
    localparam int TMO = 2000;
    localparam int RETRIES = 2;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = RETRIES + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error;
    int         checks = 0, fails = 0;
    int         cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, rel_cyc = 0, err_cyc = 0;
    logic       prev_clk_oe = 1'b0;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_SETUP(SETUP),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES(RETRIES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_ready(tx_ready),
        .busy(busy),
        .tx_done(tx_done),
        .tx_error(tx_error)
    );

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always @(negedge clk) begin
        cyc++;
        if (tx_done) done_cnt++;
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (tx_done && tx_error) both_cnt++;
        if (prev_clk_oe && !ps2_clk_oe) rel_cyc = cyc;
        prev_clk_oe = ps2_clk_oe;
    end

    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic dev_frame(input int pulses, input bit ack, output logic [9:0] got,
                             output int inh, output int req, output bit ok);
        int w;
        w = 0;
        got = '0;
        inh = 0;
        req = 0;
        while (!ps2_clk_oe && w < 3000) begin
            @(negedge clk);
            w++;
        end
        ok = ps2_clk_oe;
        if (!ok) return;
        while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
            inh++;
            @(negedge clk);
        end
        while (ps2_clk_oe && ps2_data_oe && req < 1000) begin
            req++;
            @(negedge clk);
        end
        ok = !ps2_clk_oe && ps2_data_oe;
        if (!ok) return;
        repeat (10) @(negedge clk);
        for (int i = 0; i < pulses && i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            got[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        if (pulses > 10) begin
            dev_data = !ack;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (ack ? 20 : 2) @(negedge clk);
            dev_clk = 1'b1;
            if (ack) begin
                repeat (5) @(negedge clk);
                dev_data = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
    endtask

    task automatic do_frame(input string nm, input logic [7:0] b, input bit ack, output logic [9:0] got);
        int  inh, req, d0, e0, w;
        bit  ok;
        d0 = done_cnt;
        e0 = err_cnt;
        check({nm, " ready"}, tx_ready, 1);
        send(b);
        for (int a = 0; a < (ack ? 1 : ATTEMPTS); a++) begin
            fork
                dev_frame(11, ack, got, inh, req, ok);
                if (a == 0) begin
                    repeat (3) @(negedge clk);
                    send(~b);
                end
            join
            check({nm, " request"}, ok, 1);
            check({nm, " inhibit"}, inh, INH);
            check({nm, " setup"}, req, SETUP);
            check({nm, " bits"}, got, frame_bits(b));
        end
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        check({nm, " done"}, done_cnt - d0, ack ? 1 : 0);
        check({nm, " error"}, err_cnt - e0, ack ? 0 : 1);
        check({nm, " ready after"}, tx_ready, 1);
        check({nm, " lines"}, {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        vec_t       vecs[6];
        logic [9:0] got, exp_bits;
        int         inh, req, d0, e0, w, hi;
        bit         ok, rack;
        logic [7:0] rb;

        vecs[0] = '{8'hED, 1'b1, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b0};
        vecs[5] = '{8'hED, 1'b0, 1'b1};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset ready", tx_ready, 1);
        check("reset busy", busy, 0);
        check("reset lines", {ps2_clk_oe, ps2_data_oe}, 0);
        check("reset pulses", {tx_done, tx_error}, 0);

        for (int i = 0; i < 6; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, got);
            check($sformatf("vec%0d parity", i), got[8], vecs[i].par);
        end

        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C);
        exp_bits = frame_bits(8'h3C);
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_frame(4, 1'b1, got, inh, req, ok);
            check("stall request", ok, 1);
            check("stall bits", got[3:0], exp_bits[3:0]);
            if (a == 0) begin
                repeat (50) @(negedge clk);
                send(8'h55);
            end
        end
        w = 0;
        while (err_cnt == e0 && w < 2500) begin
            @(negedge clk);
            w++;
        end
        check("timeout latency", err_cyc - rel_cyc, TMO);
        check("timeout error", err_cnt - e0, 1);
        check("timeout done", done_cnt - d0, 0);
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (ps2_clk_oe) hi++;
        end
        check("ignored start", hi, 0);
        check("ready after timeout", tx_ready, 1);

        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        dev_frame(5, 1'b1, got, inh, req, ok);
        exp_bits = frame_bits(8'hED);
        check("mid bits", got[4:0], exp_bits[4:0]);
        check("mid data_oe", ps2_data_oe, 1);
        check("mid busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid reset lines", {ps2_clk_oe, ps2_data_oe}, 0);
        check("mid reset ready", {tx_ready, busy}, 2);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("mid reset pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        do_frame("after reset", 8'hF4, 1'b1, got);

        d0 = done_cnt;
        send(8'h5A);
        fork
            dev_frame(11, 1'b1, got, inh, req, ok);
            begin
                w = 0;
                while (!tx_done && w < 1500) begin
                    @(negedge clk);
                    w++;
                end
                tx_data = 8'h33;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (ps2_clk_oe) hi++;
        end
        check("done-cycle start", hi, 0);
        check("done-cycle bits", got, frame_bits(8'h5A));
        check("done-cycle done", done_cnt - d0, 1);

        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            do_frame($sformatf("rand%0d", i), rb, rack, got);
        end

        check("done and error together", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs or 0xFF reset) from the CPU/IO side to the keyboard over the same open-drain PS/2 clock and data lines that ps2_keyboard receives on. It runs the full host request: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, and device acknowledge. It sits beside ps2_keyboard in video_game; its busy output masks the receiver while a frame is in flight.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before the request (100 us at 50 MHz)
START_SETUP, 16, clk cycles data is held low before ps2 clock is released
TIMEOUT_CYCLES, 750000, clk cycles allowed from clock release to ack-complete (15 ms at 50 MHz)
MAX_RETRIES, 2, extra attempts after a failed frame (used only with PS2_TX_RETRY_EN)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-low reset
tx_start  in  1  request pulse; sampled only while tx_ready=1
tx_data  in  8  command byte, latched on the accepted tx_start
ps2_clk_in  in  1  PS/2 clock pin level (asynchronous)
ps2_data_in  in  1  PS/2 data pin level (asynchronous)
ps2_clk_oe  out  1  1 = drive ps2 clock low, 0 = release
ps2_data_oe  out  1  1 = drive ps2 data low, 0 = release
tx_ready  out  1  1 only in IDLE
busy  out  1  equals ~tx_ready
tx_done  out  1  one-cycle pulse when the device acks
tx_error  out  1  one-cycle pulse on NACK or timeout

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE.
  - ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, tx_ready=1, busy=0.
  - All counters and the shift register clear.
  - Reset mid-frame releases both lines on the next edge. No done or error pulse is produced.
- Input synchronisation:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - fall = 1 for one cycle when synced clock goes 1 -> 0.
- Outputs are registered. Line changes appear one cycle after the state or fall event that causes them.
- States and transitions:
  - IDLE:
    - Both lines released.
    - tx_start=1 latches tx_data, computes parity = ~^tx_data, clears bit_cnt, goes to INHIBIT.
  - INHIBIT:
    - ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ:
    - ps2_clk_oe=1, ps2_data_oe=1 (start bit 0) for START_SETUP cycles.
    - Then go to SEND and clear the timeout counter.
  - SEND:
    - ps2_clk_oe=0; the device generates the clock.
    - On each fall, bit_cnt increments and ps2_data_oe is set:
      - falls 1-8: ps2_data_oe = ~tx_data[fall-1]
      - fall 9: ps2_data_oe = ~parity
      - fall 10: ps2_data_oe = 0 (stop bit)
    - Fall 11: sample synced data.
      - 0 -> WAIT_IDLE.
      - 1 -> FAIL (NACK).
  - WAIT_IDLE:
    - When synced clock=1 and synced data=1 on the same cycle, go to DONE.
  - DONE: tx_done=1 for one cycle, then IDLE.
  - FAIL: both lines released; tx_error=1 for one cycle, then IDLE.
- Timeout:
  - Counter runs in SEND and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES goes to FAIL regardless of bit_cnt.
- Boundary rules:
  - tx_start while busy is ignored; the latched byte is unchanged.
  - tx_start on the same cycle as the DONE/FAIL pulse is ignored, because tx_ready is still 0.
  - Falls during INHIBIT or REQ are ignored.
- tx_done and tx_error are never asserted together.

Optional Feature:
PS2_TX_RETRY_EN
- Defined:
  - FAIL checks retry_cnt.
  - If retry_cnt < MAX_RETRIES: increment retry_cnt and return to INHIBIT with the same latched byte. No tx_error pulse; busy stays 1.
  - tx_error pulses only after attempt MAX_RETRIES+1 fails.
  - retry_cnt clears on IDLE entry and on reset.
- Undefined: no retry logic; the first failure pulses tx_error; MAX_RETRIES is unused.

Test Plan (INHIBIT_CYCLES=8, START_SETUP=4, TIMEOUT_CYCLES=2000, device model clocks at 40 clk cycles per PS/2 period):
1. Reset low for 3 cycles, then release -> tx_ready=1, busy=0, both oe=0, tx_done=0, tx_error=0.
2. tx_start with tx_data=0xED, device acks -> clock low 8 cycles, then data low 4 cycles. Device samples bits 1,0,1,1,0,1,1,1, parity=1, stop=1. tx_done pulses once; tx_ready=1 afterwards.
3. tx_data=0x01, then 0x00 -> sampled parity 0, then 1.
4. Device returns data=1 at the ack clock -> tx_error pulses once, no tx_done, lines released. With PS2_TX_RETRY_EN: three full frames of the same byte before a single tx_error.
5. Device stops clocking after 4 bits -> tx_error exactly TIMEOUT_CYCLES cycles after clock release. tx_start=0x55 during the frame is ignored.
6. reset=0 during SEND at bit 5 -> next edge: both oe=0, state IDLE, no pulse. A new 0xF4 frame then completes with tx_done.
